mac8s_accumulator: RTL and testbench

Pipelined signed multiply-accumulate stage that sits directly downstream of the team's exact signed 8x8 multiplier. It accepts a valid/ready stream of signed 8-bit operand pairs grouped by a `last` flag, multiplies each pair exactly, and accumulates the 16-bit products into a wide signed sum. One result per group is presented on a valid/ready output port. This is the dot-product building block for the approximate-vs-exact multiplier evaluation datapath.

---
 rtl/mac8s_pkg.sv | 18 +
 rtl/mac8s_accumulator_mul8s_stage.sv | 58 +++++
 rtl/mac8s_accumulator.sv | 148 ++++++++++++++
 tb/tb_mac8s_accumulator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac8s_pkg.sv
// Shared types and constants for the signed 8x8 multiply-accumulate slice.
//   OP_W        operand width (signed, two's complement)
//   PROD_W      exact product width
//   acc_state_t accumulator FSM state encoding
//   prod_t      signed product type
package mac8s_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_t;

   typedef logic signed [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mac8s_accumulator_mul8s_stage.sv
// mul8s_stage: S1 operand register and S2 product register with the exact
// signed 8x8 multiply between them. Both stages advance only when en_i is high.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en_i              pipeline advance (low = hold everything)
//   valid_i, last_i   incoming beat qualifiers
//   a_i, b_i          signed operands
//   p_o               exact signed product (S2)
//   valid_o, last_o   S2 beat qualifiers
module mul8s_stage
   import mac8s_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en_i,
   input  logic                   valid_i,
   input  logic                   last_i,
   input  logic signed [OP_W-1:0] a_i,
   input  logic signed [OP_W-1:0] b_i,
   output prod_t                  p_o,
   output logic                   valid_o,
   output logic                   last_o
);

   logic signed [OP_W-1:0] a_q, b_q;
   logic                   s1_valid_q, s1_last_q;
   prod_t                  p_q, p_d;
   logic                   s2_valid_q, s2_last_q;

   // Exact signed multiplier: operands sign-extended to the product width so
   // the 16-bit result is exact, including (-128)*(-128) = +16384.
   assign p_d = PROD_W'(a_q) * PROD_W'(b_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         p_q        <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
      end else if (en_i) begin
         a_q        <= a_i;
         b_q        <= b_i;
         s1_valid_q <= valid_i;
         s1_last_q  <= last_i;
         p_q        <= p_d;
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
      end
   end

   assign p_o     = p_q;
   assign valid_o = s2_valid_q;
   assign last_o  = s2_last_q;

endmodule

// File: rtl/mac8s_accumulator.sv
// mac8s_accumulator: pipelined signed multiply-accumulate. Groups of signed
// 8-bit operand pairs (closed by in_last_i or by reaching MAX_LEN terms) are
// multiplied exactly and summed; one result per group is offered downstream.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid_i / in_ready_o    operand beat handshake
//   in_a_i, in_b_i, in_last_i  signed operands, group terminator
//   out_valid_o / out_ready_i  result handshake (result held until accepted)
//   out_acc_o                  signed group sum (wraps modulo 2^ACC_W)
//   out_count_o                terms in the group
//   out_ovf_o                  signed overflow seen anywhere in the group
//   out_forced_o               group closed by MAX_LEN rather than in_last_i
//
// state | meaning
// IDLE  | no group open, acc/cnt/ovf are zero
// ACCUM | group open, acc/cnt/ovf hold the partial result
module mac8s_accumulator
   import mac8s_pkg::*;
#(
   parameter  int ACC_W   = 24,
   parameter  int MAX_LEN = 256,
   localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic signed [OP_W-1:0]  in_a_i,
   input  logic signed [OP_W-1:0]  in_b_i,
   input  logic                    in_last_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [ACC_W-1:0] out_acc_o,
   output logic [CNT_W-1:0]        out_count_o,
   output logic                    out_ovf_o,
   output logic                    out_forced_o
);

   logic  stall;
   prod_t s2_p;
   logic  s2_valid, s2_last;

   acc_state_t              state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;

   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
   logic [CNT_W-1:0]        out_count_q, out_count_d;
   logic                    out_ovf_q, out_ovf_d;
   logic                    out_forced_q, out_forced_d;

   logic signed [ACC_W-1:0] p_ext, acc_base, acc_sum;
   logic [CNT_W-1:0]        cnt_base, cnt_sum;
   logic                    ovf_base, add_ovf, ovf_sum, close;

   // Only an unaccepted result blocks the pipe; no path from in_valid_i.
   assign stall      = out_valid_q & ~out_ready_i;
   assign in_ready_o = ~stall;

   mul8s_stage u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (~stall),
      .valid_i (in_valid_i),
      .last_i  (in_last_i),
      .a_i     (in_a_i),
      .b_i     (in_b_i),
      .p_o     (s2_p),
      .valid_o (s2_valid),
      .last_o  (s2_last)
   );

   // Size cast of a signed value sign-extends, also valid when ACC_W == PROD_W.
   assign p_ext    = ACC_W'(s2_p);
   assign acc_base = (state_q == IDLE) ? '0 : acc_q;
   assign cnt_base = (state_q == IDLE) ? '0 : cnt_q;
   assign ovf_base = (state_q == IDLE) ? 1'b0 : ovf_q;
   assign acc_sum  = acc_base + p_ext;
   assign cnt_sum  = cnt_base + CNT_W'(1);
   assign add_ovf  = (acc_base[ACC_W-1] == p_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
   assign ovf_sum  = ovf_base | add_ovf;
   assign close    = s2_valid & (s2_last | (cnt_sum == CNT_W'(MAX_LEN)));

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      out_valid_d  = out_valid_q & ~out_ready_i;
      out_acc_d    = out_acc_q;
      out_count_d  = out_count_q;
      out_ovf_d    = out_ovf_q;
      out_forced_d = out_forced_q;
      if (!stall && s2_valid) begin
         if (close) begin
            // A close in the same cycle as acceptance reloads the output.
            out_valid_d  = 1'b1;
            out_acc_d    = acc_sum;
            out_count_d  = cnt_sum;
            out_ovf_d    = ovf_sum;
            out_forced_d = ~s2_last;
            state_d      = IDLE;
            acc_d        = '0;
            cnt_d        = '0;
            ovf_d        = 1'b0;
         end else begin
            state_d = ACCUM;
            acc_d   = acc_sum;
            cnt_d   = cnt_sum;
            ovf_d   = ovf_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_acc_q    <= '0;
         out_count_q  <= '0;
         out_ovf_q    <= 1'b0;
         out_forced_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         out_valid_q  <= out_valid_d;
         out_acc_q    <= out_acc_d;
         out_count_q  <= out_count_d;
         out_ovf_q    <= out_ovf_d;
         out_forced_q <= out_forced_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_acc_o    = out_acc_q;
   assign out_count_o  = out_count_q;
   assign out_ovf_o    = out_ovf_q;
   assign out_forced_o = out_forced_q;

endmodule

// File: tb/tb_mac8s_accumulator.sv
// Directed bench for mac8s_accumulator. Three instances share the input beat
// stream: u_main (ACC_W=24, MAX_LEN=256), u_ovf (ACC_W=16) and u_max
// (MAX_LEN=4). Only u_main ever sees out_ready low; the others always accept.
module tb_mac8s_accumulator;

   typedef struct {
      logic [23:0] acc;
      logic [8:0]  cnt;
      logic        ovf;
      logic        forced;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic signed [7:0] in_a = '0, in_b = '0;
   logic in_last = 1'b0;
   logic rdy_m = 1'b1;
   logic rdy_o = 1'b1;
   logic rdy_x = 1'b1;

   logic        ir_m, ov_m, ovf_m, frc_m;
   logic [23:0] acc_m;
   logic [8:0]  cnt_m;
   logic        ir_o, ov_o, ovf_o, frc_o;
   logic [15:0] acc_o;
   logic [8:0]  cnt_o;
   logic        ir_x, ov_x, ovf_x, frc_x;
   logic [23:0] acc_x;
   logic [2:0]  cnt_x;

   res_t q_m[$];
   res_t q_o[$];
   res_t q_x[$];
   res_t r;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mac8s_accumulator #(.ACC_W(24), .MAX_LEN(256)) u_main (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir_m),
      .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
      .out_valid_o(ov_m), .out_ready_i(rdy_m), .out_acc_o(acc_m),
      .out_count_o(cnt_m), .out_ovf_o(ovf_m), .out_forced_o(frc_m));

   mac8s_accumulator #(.ACC_W(16), .MAX_LEN(256)) u_ovf (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir_o),
      .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
      .out_valid_o(ov_o), .out_ready_i(rdy_o), .out_acc_o(acc_o),
      .out_count_o(cnt_o), .out_ovf_o(ovf_o), .out_forced_o(frc_o));

   mac8s_accumulator #(.ACC_W(24), .MAX_LEN(4)) u_max (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(ir_x),
      .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
      .out_valid_o(ov_x), .out_ready_i(rdy_x), .out_acc_o(acc_x),
      .out_count_o(cnt_x), .out_ovf_o(ovf_x), .out_forced_o(frc_x));

   // Record every accepted result; inputs only change at posedge+1.
   always @(negedge clk) begin
      if (ov_m && rdy_m) q_m.push_back('{acc_m, cnt_m, ovf_m, frc_m});
      if (ov_o && rdy_o) q_o.push_back('{{8'h00, acc_o}, cnt_o, ovf_o, frc_o});
      if (ov_x && rdy_x) q_x.push_back('{acc_x, {6'b0, cnt_x}, ovf_x, frc_x});
   end

   task automatic send(input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic l);
      int g;
      in_a = a; in_b = b; in_last = l; in_valid = 1'b1; g = 0;
      @(negedge clk);
      while (!ir_m && g < 100) begin
         g++;
         @(negedge clk);
      end
      if (g >= 100) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout in_ready=%b want 1", ir_m);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_res(input int which, input int n);
      int sz;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         sz = (which == 0) ? q_m.size() : (which == 1) ? q_o.size() : q_x.size();
         if (sz >= n) return;
      end
      n_vec++; n_err++;
      $display("FAIL wait_res_timeout inst=%0d got=%0d want=%0d results", which, sz, n);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; rdy_m = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (ov_m !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b want=0", ov_m); end
      n_vec++; if (acc_m !== 24'd0) begin n_err++; $display("FAIL rst_acc got=%h want=0", acc_m); end
      n_vec++; if (cnt_m !== 9'd0) begin n_err++; $display("FAIL rst_count got=%0d want=0", cnt_m); end
      n_vec++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%b want=0", ovf_m); end
      n_vec++; if (frc_m !== 1'b0) begin n_err++; $display("FAIL rst_forced got=%b want=0", frc_m); end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (ir_m !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", ir_m); end
      @(posedge clk); #1;
      q_m.delete(); q_o.delete(); q_x.delete();
   endtask

   // Accepting edge is the first of three; out_valid is seen after the third.
   task automatic test_single;
      q_m.delete();
      in_a = -8'sd128; in_b = -8'sd128; in_last = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      n_vec++; if (ov_m !== 1'b0) begin n_err++; $display("FAIL single_lat1 got=%b want=0", ov_m); end
      @(negedge clk);
      n_vec++; if (ov_m !== 1'b0) begin n_err++; $display("FAIL single_lat2 got=%b want=0", ov_m); end
      @(negedge clk);
      n_vec++; if (ov_m !== 1'b1) begin n_err++; $display("FAIL single_lat3 got=%b want=1", ov_m); end
      n_vec++; if (acc_m !== 24'd16384) begin n_err++; $display("FAIL single_acc got=%0d want=16384", $signed(acc_m)); end
      n_vec++; if (cnt_m !== 9'd1) begin n_err++; $display("FAIL single_count got=%0d want=1", cnt_m); end
      n_vec++; if (ovf_m !== 1'b0 || frc_m !== 1'b0) begin n_err++; $display("FAIL single_flags got=%b%b want=00", ovf_m, frc_m); end
      @(posedge clk); #1;
      n_vec++; if (ov_m !== 1'b0) begin n_err++; $display("FAIL single_drop got=%b want=0", ov_m); end
   endtask

   task automatic test_group4;
      q_m.delete();
      send(8'sd3, 8'sd4, 1'b0);
      send(-8'sd5, 8'sd6, 1'b0);
      send(8'sd127, 8'sd127, 1'b0);
      send(-8'sd1, -8'sd1, 1'b1);
      wait_res(0, 1);
      if (q_m.size() > 0) begin
         r = q_m.pop_front();
         n_vec++; if (r.acc !== 24'd16112) begin n_err++; $display("FAIL g4_acc got=%0d want=16112", $signed(r.acc)); end
         n_vec++; if (r.cnt !== 9'd4) begin n_err++; $display("FAIL g4_count got=%0d want=4", r.cnt); end
         n_vec++; if (r.ovf !== 1'b0 || r.forced !== 1'b0) begin n_err++; $display("FAIL g4_flags got=%b%b want=00", r.ovf, r.forced); end
      end
   endtask

   task automatic test_overflow;
      q_o.delete();
      send(-8'sd128, -8'sd128, 1'b0);
      send(-8'sd128, -8'sd128, 1'b0);
      send(-8'sd128, -8'sd128, 1'b1);
      wait_res(1, 1);
      if (q_o.size() > 0) begin
         r = q_o.pop_front();
         n_vec++; if (r.acc !== 24'h00C000) begin n_err++; $display("FAIL ovf_acc got=%h want=00c000", r.acc); end
         n_vec++; if (r.cnt !== 9'd3) begin n_err++; $display("FAIL ovf_count got=%0d want=3", r.cnt); end
         n_vec++; if (r.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b want=1", r.ovf); end
         n_vec++; if (r.forced !== 1'b0) begin n_err++; $display("FAIL ovf_forced got=%b want=0", r.forced); end
      end
   endtask

   task automatic test_maxlen;
      q_x.delete();
      for (int i = 0; i < 6; i++) send(8'sd1, 8'sd1, (i == 5));
      wait_res(2, 2);
      if (q_x.size() >= 2) begin
         r = q_x.pop_front();
         n_vec++; if (r.cnt !== 9'd4 || r.acc !== 24'd4) begin n_err++; $display("FAIL max1_cnt_acc got=%0d/%0d want=4/4", r.cnt, r.acc); end
         n_vec++; if (r.forced !== 1'b1 || r.ovf !== 1'b0) begin n_err++; $display("FAIL max1_flags got=f%b o%b want=f1 o0", r.forced, r.ovf); end
         r = q_x.pop_front();
         n_vec++; if (r.cnt !== 9'd2 || r.acc !== 24'd2) begin n_err++; $display("FAIL max2_cnt_acc got=%0d/%0d want=2/2", r.cnt, r.acc); end
         n_vec++; if (r.forced !== 1'b0) begin n_err++; $display("FAIL max2_forced got=%b want=0", r.forced); end
      end
   endtask

   // Groups: (1,2)(3,4)=14 ; (5,6)(-7,8)=-26 ; (10,10)=100
   task automatic test_back_to_back;
      int g;
      q_m.delete();
      rdy_m = 1'b0;
      fork
         begin
            send(8'sd1, 8'sd2, 1'b0);
            send(8'sd3, 8'sd4, 1'b1);
            send(8'sd5, 8'sd6, 1'b0);
            send(-8'sd7, 8'sd8, 1'b1);
            send(8'sd10, 8'sd10, 1'b1);
         end
         begin
            g = 0;
            while (!ov_m && g < 40) begin
               @(posedge clk); #1; g++;
            end
            n_vec++; if (ov_m !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got=%b want=1", ov_m); end
            n_vec++; if (ir_m !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_drop got=%b want=0", ir_m); end
            for (int i = 0; i < 5; i++) begin
               @(posedge clk); #1;
               n_vec++;
               if (ov_m !== 1'b1 || acc_m !== 24'd14 || cnt_m !== 9'd2 || ir_m !== 1'b0) begin
                  n_err++;
                  $display("FAIL b2b_hold%0d got v=%b acc=%0d cnt=%0d ir=%b want v=1 acc=14 cnt=2 ir=0",
                           i, ov_m, acc_m, cnt_m, ir_m);
               end
            end
            rdy_m = 1'b1;
         end
      join
      wait_res(0, 3);
      n_vec++; if (q_m.size() != 3) begin n_err++; $display("FAIL b2b_nres got=%0d want=3", q_m.size()); end
      if (q_m.size() >= 3) begin
         r = q_m.pop_front();
         n_vec++; if (r.acc !== 24'd14 || r.cnt !== 9'd2) begin n_err++; $display("FAIL b2b_r1 got=%0d/%0d want=14/2", $signed(r.acc), r.cnt); end
         r = q_m.pop_front();
         n_vec++; if (r.acc !== 24'hFFFFE6 || r.cnt !== 9'd2) begin n_err++; $display("FAIL b2b_r2 got=%0d/%0d want=-26/2", $signed(r.acc), r.cnt); end
         r = q_m.pop_front();
         n_vec++; if (r.acc !== 24'd100 || r.cnt !== 9'd1) begin n_err++; $display("FAIL b2b_r3 got=%0d/%0d want=100/1", $signed(r.acc), r.cnt); end
      end
   endtask

   task automatic test_reset_mid;
      q_m.delete();
      send(8'sd1, 8'sd1, 1'b0);
      send(8'sd2, 8'sd2, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++; if (ov_m !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b want=0", ov_m); end
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      q_m.delete();
      send(8'sd2, 8'sd3, 1'b1);
      wait_res(0, 1);
      repeat (5) @(posedge clk);
      #1;
      n_vec++; if (q_m.size() != 1) begin n_err++; $display("FAIL mid_nres got=%0d want=1", q_m.size()); end
      if (q_m.size() > 0) begin
         r = q_m.pop_front();
         n_vec++; if (r.acc !== 24'd6 || r.cnt !== 9'd1) begin n_err++; $display("FAIL mid_res got=%0d/%0d want=6/1", $signed(r.acc), r.cnt); end
         n_vec++; if (r.ovf !== 1'b0 || r.forced !== 1'b0) begin n_err++; $display("FAIL mid_flags got=%b%b want=00", r.ovf, r.forced); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_group4();
      test_overflow();
      test_maxlen();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
